// File: rtl/time_frame_streamer_if.sv
// Byte-stream channel from the frame renderer to the OLED page writer.
// The master drives data/valid/last and the slave drives ready.
interface time_frame_streamer_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/time_frame_streamer.sv
// Renders packed HH:MM:SS into a 5x7 column-font byte frame and streams it out.
// Optional macro COLON_BLINK_EN blanks both colons while the seconds ones digit is odd.
module time_frame_streamer #(
  parameter int unsigned GAP_COLS = 1,
  parameter int unsigned GLYPH_W  = 5
) (
  input  logic                          CLK,
  input  logic                          NRST,
  input  logic [6:0]                    hr,
  input  logic [6:0]                    min,
  input  logic [6:0]                    sec,
  input  logic                          force_req,
  time_frame_streamer_if.master         m,
  output logic                          busy
);

  localparam int unsigned COLS     = GLYPH_W + GAP_COLS;
  localparam logic [2:0]  LAST_COL = 3'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [6:0] snap_hr_q, snap_hr_d, snap_min_q, snap_min_d, snap_sec_q, snap_sec_d;
  logic       pending_q, pending_d;
  logic [2:0] char_q, char_d, col_q, col_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       changed;
  logic [2:0] char_n, col_n;

  function automatic logic [7:0] font_col(input logic [3:0] d, input logic [2:0] col);
    logic [39:0] g;
    logic [7:0]  b;
    case (d)
      4'd0:    g = 40'h3E_51_49_45_3E;
      4'd1:    g = 40'h00_42_7F_40_00;
      4'd2:    g = 40'h42_61_51_49_46;
      4'd3:    g = 40'h21_41_45_4B_31;
      4'd4:    g = 40'h18_14_12_7F_10;
      4'd5:    g = 40'h27_45_45_45_39;
      4'd6:    g = 40'h3C_4A_49_49_30;
      4'd7:    g = 40'h01_71_09_05_03;
      4'd8:    g = 40'h36_49_49_49_36;
      4'd9:    g = 40'h06_49_49_29_1E;
      default: g = '0;
    endcase
    case (col)
      3'd0:    b = g[39:32];
      3'd1:    b = g[31:24];
      3'd2:    b = g[23:16];
      3'd3:    b = g[15:8];
      3'd4:    b = g[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  // Character slots: H1 H0 ':' M1 M0 ':' S1 S0; tens fields are zero-extended.
  function automatic logic [7:0] render(input logic [6:0] h, input logic [6:0] mi,
                                        input logic [6:0] s, input logic [2:0] ch,
                                        input logic [2:0] col);
    logic [3:0] d;
    logic       colon;
    logic [7:0] b;
    d     = '0;
    colon = 1'b0;
    case (ch)
      3'd0:    d = {1'b0, h[6:4]};
      3'd1:    d = h[3:0];
      3'd3:    d = {1'b0, mi[6:4]};
      3'd4:    d = mi[3:0];
      3'd6:    d = {1'b0, s[6:4]};
      3'd7:    d = s[3:0];
      default: colon = 1'b1;
    endcase
    if (colon) begin
      b = (col == 3'd1 || col == 3'd2) ? 8'h36 : 8'h00;
`ifdef COLON_BLINK_EN
      if (s[0]) b = 8'h00;
`endif
    end else begin
      b = font_col(d, col);
    end
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    hr_d       = hr;
    min_d      = min;
    sec_d      = sec;
    snap_hr_d  = snap_hr_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    char_d     = char_q;
    col_d      = col_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    busy_d     = busy_q;
    char_n     = char_q;
    col_n      = col_q;
    changed    = {hr_q, min_q, sec_q} != {snap_hr_q, snap_min_q, snap_sec_q};
    pending_d  = pending_q | changed | force_req;

    case (state_q)
      IDLE: begin
        if (pending_q) state_d = LOAD;
      end
      LOAD: begin
        // The first byte renders from the values being captured, not the old snapshot.
        snap_hr_d  = hr_q;
        snap_min_d = min_q;
        snap_sec_d = sec_q;
        pending_d  = force_req;
        char_d     = '0;
        col_d      = '0;
        busy_d     = 1'b1;
        valid_d    = 1'b1;
        last_d     = 1'b0;
        data_d     = render(hr_q, min_q, sec_q, 3'd0, 3'd0);
        state_d    = SEND;
      end
      SEND: begin
        if (valid_q && m.m_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            data_d  = '0;
            state_d = IDLE;
          end else begin
            if (col_q == LAST_COL) begin
              col_n  = '0;
              char_n = char_q + 3'd1;
            end else begin
              col_n  = col_q + 3'd1;
            end
            char_d = char_n;
            col_d  = col_n;
            data_d = render(snap_hr_q, snap_min_q, snap_sec_q, char_n, col_n);
            last_d = (char_n == 3'd7) && (col_n == LAST_COL);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= IDLE;
      hr_q       <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      snap_hr_q  <= '0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      pending_q  <= 1'b1;
      char_q     <= '0;
      col_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hr_q       <= hr_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      snap_hr_q  <= snap_hr_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      pending_q  <= pending_d;
      char_q     <= char_d;
      col_q      <= col_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;
  assign m.m_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_time_frame_streamer.sv
// Directed bench for time_frame_streamer: frame content, handshake, coalescing, reset.
module tb_time_frame_streamer;
  localparam int COLS   = 6;
  localparam int NBYTES = 8 * COLS;

  logic       CLK;
  logic       NRST;
  logic [6:0] hr_i, min_i, sec_i;
  logic       force_i;
  logic       busy;

  time_frame_streamer_if bus ();

  time_frame_streamer #(.GAP_COLS(1), .GLYPH_W(5)) dut (
    .CLK      (CLK),
    .NRST     (NRST),
    .hr       (hr_i),
    .min      (min_i),
    .sec      (sec_i),
    .force_req(force_i),
    .m        (bus.master),
    .busy     (busy)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] got_data [0:63];
  logic       got_last [0:63];
  int         nbytes;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int code, input int c);
    logic [39:0] g;
    case (code)
      0:  g = 40'h3E5149453E;
      1:  g = 40'h00427F4000;
      2:  g = 40'h4261514946;
      3:  g = 40'h2141454B31;
      4:  g = 40'h1814127F10;
      5:  g = 40'h2745454539;
      6:  g = 40'h3C4A494930;
      7:  g = 40'h0171090503;
      8:  g = 40'h3649494936;
      9:  g = 40'h064949291E;
      16: g = 40'h0036360000;
      default: g = '0;
    endcase
    if (c > 4) return 8'h00;
    return g[8*(4-c) +: 8];
  endfunction

  function automatic logic [7:0] exp_byte(input logic [6:0] h, input logic [6:0] mi,
                                          input logic [6:0] s, input int idx);
    int ch, c, code, colon_code;
    ch = idx / COLS;
    c  = idx % COLS;
    colon_code = 16;
`ifdef COLON_BLINK_EN
    if (s[0]) colon_code = 17;
`endif
    case (ch)
      0: code = int'(h[6:4]);
      1: code = int'(h[3:0]);
      3: code = int'(mi[6:4]);
      4: code = int'(mi[3:0]);
      6: code = int'(s[6:4]);
      7: code = int'(s[3:0]);
      default: code = colon_code;
    endcase
    return glyph(code, c);
  endfunction

  // Collects accepted bytes; optionally stops early or changes sec mid-frame.
  task automatic collect(input bit rnd, input int stop_at, input bit do_chg, output int n);
    bit         done, stall;
    logic [8:0] stall_v;
    n     = 0;
    done  = 0;
    stall = 0;
    stall_v = '0;
    bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (stall) begin
        check("stall_valid", {31'd0, bus.m_valid}, 32'd1);
        check("stall_data_last", {23'd0, bus.m_last, bus.m_data}, {23'd0, stall_v});
        stall = 0;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (n < 64) begin
          got_data[n] = bus.m_data;
          got_last[n] = bus.m_last;
        end
        n++;
        if (do_chg) begin
          if (n == 10) sec_i = 7'h58;
          if (n == 20) sec_i = 7'h59;
          if (n == 30) sec_i = 7'h21;
        end
        if (bus.m_last || n >= 64) begin
          tick();
          done = 1;
        end
      end else if (bus.m_valid) begin
        stall   = 1;
        stall_v = {bus.m_last, bus.m_data};
      end
      if (stop_at >= 0 && n == stop_at) done = 1;
      if (!done) begin
        tick();
        bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    check("frame_done_in_budget", {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [6:0] h, input logic [6:0] mi,
                             input logic [6:0] s);
    check({tag, "_count"}, n_to_u(nbytes), NBYTES);
    for (int i = 0; i < NBYTES && i < nbytes; i++) begin
      check($sformatf("%s_byte%0d", tag, i), {23'd0, got_last[i], got_data[i]},
            {23'd0, (i == NBYTES - 1), exp_byte(h, mi, s, i)});
    end
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_valid_after"}, {31'd0, bus.m_valid}, 32'd0);
  endtask

  function automatic logic [31:0] n_to_u(input int v);
    return 32'(v);
  endfunction

  initial begin
    int idle_valid;
    NRST = 1'b0; hr_i = '0; min_i = '0; sec_i = '0; force_i = 1'b0; bus.m_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_last", {31'd0, bus.m_last}, 32'd0);
    check("rst_data", {24'd0, bus.m_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    // Reset release: pending from reset renders 00:00:00
    NRST = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    check("t1_load_valid", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("t1_first_valid", {31'd0, bus.m_valid}, 32'd1);
    check("t1_first_busy", {31'd0, busy}, 32'd1);
    check("t1_first_data", {24'd0, bus.m_data}, 32'h3E);
    collect(0, -1, 0, nbytes);
    check_frame("t1", 7'h00, 7'h00, 7'h00);

    // Time change from idle
    hr_i = 7'h12; min_i = 7'h34; sec_i = 7'h56;
    collect(0, -1, 0, nbytes);
    check_frame("t2", 7'h12, 7'h34, 7'h56);

    // Force with unchanged time, latency, then random back-pressure
    force_i = 1'b1;
    bus.m_ready = 1'b0;
    tick();
    force_i = 1'b0;
    check("t3_k_valid", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("t3_k1_valid", {31'd0, bus.m_valid}, 32'd0);
    tick();
    check("t3_k2_valid", {31'd0, bus.m_valid}, 32'd1);
    check("t3_k2_busy", {31'd0, busy}, 32'd1);
    check("t3_k2_data", {24'd0, bus.m_data}, 32'h00);
    collect(1, -1, 0, nbytes);
    check_frame("t3", 7'h12, 7'h34, 7'h56);

    // Three changes inside one frame coalesce into one follow-up
    sec_i = 7'h57;
    collect(0, -1, 1, nbytes);
    check_frame("t4a", 7'h12, 7'h34, 7'h57);
    collect(0, -1, 0, nbytes);
    check_frame("t4b", 7'h12, 7'h34, 7'h21);
    idle_valid = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.m_valid) idle_valid++;
    end
    check("t4_no_extra_frame", n_to_u(idle_valid), 32'd0);

    // Blank ones digits, tens 7, then odd seconds for colon behaviour
    hr_i = 7'h7A; min_i = 7'h09; sec_i = 7'h0C;
    collect(0, -1, 0, nbytes);
    check_frame("t5a", 7'h7A, 7'h09, 7'h0C);
    sec_i = 7'h01;
    collect(0, -1, 0, nbytes);
    check_frame("t5b", 7'h7A, 7'h09, 7'h01);

    // Reset mid-frame
    hr_i = 7'h12; min_i = 7'h34; sec_i = 7'h56;
    collect(0, 20, 0, nbytes);
    check("t6_mid_valid_before", {31'd0, bus.m_valid}, 32'd1);
    NRST = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_data", {24'd0, bus.m_data}, 32'd0);
    hr_i = '0; min_i = '0; sec_i = '0;
    tick();
    tick();
    NRST = 1'b1;
    collect(0, -1, 0, nbytes);
    check_frame("t6", 7'h00, 7'h00, 7'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
